// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath word width, mul/div op encoding and mul/div FSM states.
package cpu_pkg;

    localparam int WORD_W = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } muldiv_state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the datapath (master) and the mul/div unit (slave).
interface mul_div_unit_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] z_hi;
    logic [WIDTH-1:0] z_lo;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, div_by_zero, z_hi, z_lo
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, div_by_zero, z_hi, z_lo
    );

endinterface

// File: rtl/muldiv_addsub.sv
// Combinational WIDTH+1-bit adder/subtractor shared by the Booth and non-restoring steps.
module muldiv_addsub
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] y
);

    always_comb begin
        y = sub ? (a - b) : (a + b);
    end

endmodule

// File: rtl/mul_div_unit.sv
// Sequential signed multiplier (radix-2 Booth) and divider (non-restoring, truncating).
// The divider is built only when MUL_DIV_UNIT_DIV_EN is defined.
module mul_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic          clock,
    input  logic          clear,
    mul_div_unit_if.slave bus
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             q1_q, q1_d;
    logic [WIDTH-1:0] z_hi_q, z_hi_d;
    logic [WIDTH-1:0] z_lo_q, z_lo_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   as_a, as_b, as_y;
    logic             as_sub;
    logic [WIDTH:0]   booth_acc;
    logic [WIDTH-1:0] booth_q;
`ifdef MUL_DIV_UNIT_DIV_EN
    logic             op_q, op_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] abs_a, abs_b, rem;

    assign abs_a = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
    assign abs_b = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;
    assign rem   = acc_q[WIDTH] ? as_y[WIDTH-1:0] : acc_q[WIDTH-1:0];
`endif

    muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (as_sub),
        .y   (as_y)
    );

    // Booth step result: arithmetic shift right of {acc, q} after the add/subtract.
    assign booth_acc = {as_y[WIDTH], as_y[WIDTH:1]};
    assign booth_q   = {as_y[0], q_q[WIDTH-1:1]};

    always_comb begin
        as_a   = acc_q;
        as_b   = (q_q[0] ^ q1_q) ? {m_q[WIDTH-1], m_q} : '0;
        as_sub = q_q[0];
`ifdef MUL_DIV_UNIT_DIV_EN
        // FIX restores a negative final remainder; RUN shifts in the next dividend bit.
        if (op_q == OP_DIV) begin
            as_b = {1'b0, m_q};
            if (state_q == FIX) begin
                as_sub = 1'b0;
            end else begin
                as_a   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
                as_sub = ~acc_q[WIDTH];
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        q1_d    = q1_q;
        z_hi_d  = z_hi_q;
        z_lo_d  = z_lo_q;
        dbz_d   = dbz_q;
`ifdef MUL_DIV_UNIT_DIV_EN
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    count_d = '0;
                    acc_d   = '0;
                    q1_d    = 1'b0;
                    dbz_d   = 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
                    op_d = bus.op;
`endif
                    if (bus.op == OP_MUL) begin
                        m_d     = bus.operand_a;
                        q_d     = bus.operand_b;
                        state_d = RUN;
                    end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
                        q_d       = abs_a;
                        m_d       = abs_b;
                        neg_quo_d = bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
                        neg_rem_d = bus.operand_a[WIDTH-1];
                        if (bus.operand_b == '0) begin
                            z_lo_d  = '1;
                            z_hi_d  = bus.operand_a;
                            dbz_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
`else
                        z_hi_d  = '0;
                        z_lo_d  = '0;
                        state_d = DONE;
`endif
                    end
                end
            end
            RUN: begin
                count_d = count_q + 1'b1;
`ifdef MUL_DIV_UNIT_DIV_EN
                if (op_q == OP_DIV) begin
                    acc_d = as_y;
                    q_d   = {q_q[WIDTH-2:0], ~as_y[WIDTH]};
                    if (count_q == LAST) begin
                        state_d = FIX;
                    end
                end else
`endif
                begin
                    acc_d = booth_acc;
                    q_d   = booth_q;
                    q1_d  = q_q[0];
                    if (count_q == LAST) begin
                        z_hi_d  = booth_acc[WIDTH-1:0];
                        z_lo_d  = booth_q;
                        state_d = DONE;
                    end
                end
            end
            FIX: begin
`ifdef MUL_DIV_UNIT_DIV_EN
                z_lo_d = neg_quo_q ? -q_q : q_q;
                z_hi_d = neg_rem_q ? -rem : rem;
`endif
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            q1_q    <= 1'b0;
            z_hi_q  <= '0;
            z_lo_q  <= '0;
            dbz_q   <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
            op_q      <= OP_MUL;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            q1_q    <= q1_d;
            z_hi_q  <= z_hi_d;
            z_lo_q  <= z_lo_d;
            dbz_q   <= dbz_d;
`ifdef MUL_DIV_UNIT_DIV_EN
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.div_by_zero = dbz_q;
    assign bus.z_hi        = z_hi_q;
    assign bus.z_lo        = z_lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit; divide vectors follow MUL_DIV_UNIT_DIV_EN.
module tb_mul_div_unit;
    import cpu_pkg::*;

    localparam int W       = WORD_W;
    localparam int TIMEOUT = 200;
    localparam int LAT_MUL = W + 1;
`ifdef MUL_DIV_UNIT_DIV_EN
    localparam int LAT_DIV = W + 2;
`endif

    typedef struct packed {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } vec_t;

    logic         clock;
    logic         clear;
    int           checks;
    int           failures;
    logic [W-1:0] prev_hi;
    logic [W-1:0] prev_lo;
    vec_t         vecs[$];

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic addVec(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] hi, input logic [W-1:0] lo,
                          input logic dbz, input int lat);
        vec_t v;
        v.op  = op;
        v.a   = a;
        v.b   = b;
        v.hi  = hi;
        v.lo  = lo;
        v.dbz = dbz;
        v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents a request for one accepting edge, then scrambles the inputs.
    task automatic applyStimulus(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        prev_hi       = bus.z_hi;
        prev_lo       = bus.z_lo;
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clock);
        #1;
        bus.start     = 1'b0;
        bus.op        = ~op;
        bus.operand_a = ~a;
        bus.operand_b = b + 32'd1;
    endtask

    // Called in period 1 after the accepting edge; returns the period index where done is seen.
    task automatic waitDone(output int lat, output logic busy_ok, output logic hold_ok);
        lat     = 1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!bus.done && lat <= TIMEOUT) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.z_hi !== prev_hi || bus.z_lo !== prev_lo) hold_ok = 1'b0;
            @(posedge clock);
            #1;
            lat++;
        end
        if (!bus.busy) busy_ok = 1'b0;
    endtask

    initial begin
        int   lat;
        int   k;
        int   stray;
        logic busy_ok;
        logic hold_ok;
        logic gap_busy;

        checks        = 0;
        failures      = 0;
        clear         = 1'b1;
        bus.start     = 1'b0;
        bus.op        = OP_MUL;
        bus.operand_a = '0;
        bus.operand_b = '0;

        #2 clear = 1'b0;
        #1;
        checkOutput("reset busy", 64'(bus.busy), 64'(0));
        checkOutput("reset done", 64'(bus.done), 64'(0));
        checkOutput("reset div_by_zero", 64'(bus.div_by_zero), 64'(0));
        checkOutput("reset z_hi", 64'(bus.z_hi), 64'(0));
        checkOutput("reset z_lo", 64'(bus.z_lo), 64'(0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;

        addVec(OP_MUL, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, LAT_MUL);
        addVec(OP_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, LAT_MUL);
        addVec(OP_MUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, LAT_MUL);
        addVec(OP_MUL, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000, 1'b0, LAT_MUL);
        addVec(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, LAT_MUL);
        addVec(OP_MUL, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, LAT_MUL);
`ifdef MUL_DIV_UNIT_DIV_EN
        addVec(OP_DIV, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, LAT_DIV);
        addVec(OP_DIV, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 1);
        addVec(OP_MUL, 32'hFFFFFFFB, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFE2, 1'b0, LAT_MUL);
        addVec(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, LAT_DIV);
        addVec(OP_DIV, 32'd17,       32'hFFFFFFFB, 32'h00000002, 32'hFFFFFFFD, 1'b0, LAT_DIV);
        addVec(OP_DIV, 32'hFFFFFFEF, 32'hFFFFFFFB, 32'hFFFFFFFE, 32'h00000003, 1'b0, LAT_DIV);
        addVec(OP_DIV, 32'd1000,     32'd7,        32'd6,        32'd142,      1'b0, LAT_DIV);
        addVec(OP_DIV, 32'd5,        32'd17,       32'd5,        32'd0,        1'b0, LAT_DIV);
        addVec(OP_DIV, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 1'b0, LAT_DIV);
        addVec(OP_DIV, 32'h80000000, 32'd2,        32'h00000000, 32'hC0000000, 1'b0, LAT_DIV);
`else
        addVec(OP_DIV, 32'd100,      32'd0,        32'h00000000, 32'h00000000, 1'b0, 1);
        addVec(OP_MUL, 32'hFFFFFFFB, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFE2, 1'b0, LAT_MUL);
        addVec(OP_DIV, 32'hFFFFFFEF, 32'd5,        32'h00000000, 32'h00000000, 1'b0, 1);
`endif
        addVec(OP_MUL, 32'h00012345, 32'h00010000, 32'h00000001, 32'h23450000, 1'b0, LAT_MUL);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            waitDone(lat, busy_ok, hold_ok);
            checkOutput($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            checkOutput($sformatf("v%0d z_hi", i), 64'(bus.z_hi), 64'(vecs[i].hi));
            checkOutput($sformatf("v%0d z_lo", i), 64'(bus.z_lo), 64'(vecs[i].lo));
            checkOutput($sformatf("v%0d div_by_zero", i), 64'(bus.div_by_zero), 64'(vecs[i].dbz));
            checkOutput($sformatf("v%0d busy through run", i), 64'(busy_ok), 64'(1));
            checkOutput($sformatf("v%0d outputs held during run", i), 64'(hold_ok), 64'(1));
            @(posedge clock);
            #1;
            checkOutput($sformatf("v%0d done/busy after pulse", i), 64'({bus.done, bus.busy}), 64'(0));
            checkOutput($sformatf("v%0d z_lo held", i), 64'(bus.z_lo), 64'(vecs[i].lo));
        end

        // start held high: second request waits out DONE plus one IDLE cycle.
        @(negedge clock);
        prev_hi       = bus.z_hi;
        prev_lo       = bus.z_lo;
        bus.start     = 1'b1;
        bus.op        = OP_MUL;
        bus.operand_a = 32'd3;
        bus.operand_b = 32'd4;
        @(posedge clock);
        #1;
        bus.operand_a = 32'd1000;
        bus.operand_b = 32'd1000;
        waitDone(lat, busy_ok, hold_ok);
        checkOutput("held start first latency", 64'(lat), 64'(LAT_MUL));
        checkOutput("held start first result", {bus.z_hi, bus.z_lo}, 64'd12);
        bus.operand_a = 32'hFFFFFFFE;
        bus.operand_b = 32'd9;
        k        = 0;
        gap_busy = 1'b1;
        while (k < TIMEOUT) begin
            @(posedge clock);
            #1;
            k++;
            if (k == 1) gap_busy = bus.busy;
            if (k == 2) begin
                bus.operand_a = 32'd7;
                bus.operand_b = 32'd7;
            end
            if (bus.done) break;
        end
        bus.start = 1'b0;
        checkOutput("held start idle gap busy", 64'(gap_busy), 64'(0));
        checkOutput("held start done-to-done period", 64'(k), 64'(W + 2));
        checkOutput("held start second result", {bus.z_hi, bus.z_lo}, 64'hFFFFFFFF_FFFFFFEE);

        // Clear mid-multiply: outputs drop at once and the operation is abandoned.
        applyStimulus(OP_MUL, 32'd7, 32'hFFFFFFFD);
        repeat (9) @(posedge clock);
        #2 clear = 1'b0;
        #1;
        checkOutput("clear busy", 64'(bus.busy), 64'(0));
        checkOutput("clear done", 64'(bus.done), 64'(0));
        checkOutput("clear div_by_zero", 64'(bus.div_by_zero), 64'(0));
        checkOutput("clear z_hi", 64'(bus.z_hi), 64'(0));
        checkOutput("clear z_lo", 64'(bus.z_lo), 64'(0));
        @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (bus.done || bus.busy) stray++;
        end
        checkOutput("no activity after clear", 64'(stray), 64'(0));
        applyStimulus(OP_MUL, 32'hFFFFFFFB, 32'd6);
        waitDone(lat, busy_ok, hold_ok);
        checkOutput("post-clear latency", 64'(lat), 64'(LAT_MUL));
        checkOutput("post-clear result", {bus.z_hi, bus.z_lo}, 64'hFFFFFFFF_FFFFFFE2);
        checkOutput("post-clear busy through run", 64'(busy_ok), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; results are 2*WIDTH split into z_hi/z_lo.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port clear  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-005 SHALL have port op  input  1  0 = signed multiply, 1 = signed divide.
REQ-006 SHALL have port operand_a  input  WIDTH  multiplicand/dividend (from Y register).
REQ-007 SHALL have port operand_b  input  WIDTH  multiplier/divisor (from BusMuxOut).
REQ-008 SHALL have port busy  output  1  high from accept until done cycle inclusive.
REQ-009 SHALL have port done  output  1  one-cycle pulse; results valid this cycle and after.
REQ-010 SHALL have port div_by_zero  output  1  flag for last divide; valid with done, held until next accept.
REQ-011 SHALL have port z_hi  output  WIDTH  product high half / remainder; feeds bus ZHI input.
REQ-012 SHALL have port z_lo  output  WIDTH  product low half / quotient; feeds bus ZLO input.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX, DONE; IDLE->RUN on start; RUN->FIX (divide) or DONE (multiply) after WIDTH iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-014 SHALL latch op, operand_a, operand_b on the accepting edge; later input changes SHALL not affect the operation.
REQ-015 SHALL ignore start while busy; no queuing.
REQ-016 Multiply SHALL use radix-2 Booth, one bit per cycle; done SHALL assert exactly WIDTH+1 cycles after the accepting edge.
REQ-017 Multiply result SHALL be the full 2*WIDTH-bit two's-complement product {z_hi,z_lo}.
REQ-018 Divide SHALL use non-restoring division on magnitudes with sign fixup in FIX; done SHALL assert exactly WIDTH+2 cycles after accept.
REQ-019 Divide SHALL truncate toward zero: z_lo = quotient, z_hi = remainder with sign of dividend.
REQ-020 Divisor zero SHALL skip RUN/FIX (IDLE->DONE), done 1 cycle after accept, z_lo = all ones, z_hi = dividend, div_by_zero = 1.
REQ-021 Most-negative / -1 SHALL give z_lo = most-negative (wrap), z_hi = 0, div_by_zero = 0.
REQ-022 z_hi/z_lo SHALL update only on the edge entering DONE and hold until the next completion; intermediate values SHALL never appear on outputs.
REQ-023 A start asserted in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted (back-to-back gap of 1 cycle).

Reset
REQ-024 clear low SHALL immediately force IDLE, busy=0, done=0, div_by_zero=0, z_hi=0, z_lo=0, abandoning any operation.
REQ-025 After clear deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-026 Macro MUL_DIV_UNIT_DIV_EN defined: divide as specified.
REQ-027 Macro undefined: no divider logic; op=1 accepted, done 1 cycle later, z_hi=z_lo=0, div_by_zero=0; multiply unchanged.

Structure
REQ-028 Shared package cpu_pkg SHALL hold WORD_W=32, the op encoding constants, and the FSM state typedef.
REQ-029 Sub-module muldiv_addsub SHALL provide the combinational WIDTH+1-bit add/subtract used by Booth and non-restoring steps; all sequencing stays in mul_div_unit.

Verification
REQ-030 op=0, a=7, b=-3, start -> done at cycle 33, {z_hi,z_lo}=0xFFFFFFFF_FFFFFFEB, busy high cycles 1..33.
REQ-031 op=1, a=-17, b=5 -> done at cycle 34, z_lo=0xFFFFFFFD (-3), z_hi=0xFFFFFFFE (-2).
REQ-032 op=1, a=100, b=0 -> done at cycle 1, z_lo=0xFFFFFFFF, z_hi=100, div_by_zero=1; next multiply clears flag.
REQ-033 op=1, a=0x80000000, b=0xFFFFFFFF -> z_lo=0x80000000, z_hi=0, div_by_zero=0.
REQ-034 Multiply started, clear pulsed low at cycle 10 -> all outputs 0 immediately, no done pulse; new start after release completes correctly.
REQ-035 start held high continuously -> operations accepted every WIDTH+2 (mul) cycles; operand changes mid-run do not alter results.
